// File: rtl/sram16_to_mem8_unpack_if.sv
// Bus bundle for sram16_to_mem8_unpack: load control, SRAM read port and consumer read port.
interface sram16_to_mem8_unpack_if #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 16
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] sram_addr;
    logic          sram_ren;
    logic [DW-1:0] sram_rdata;
    logic [2:0]    rd_i;
    logic [2:0]    rd_j;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;

    modport slave (
        input  start, base_addr, sram_rdata, rd_i, rd_j,
        output sram_addr, sram_ren, rd_data, busy, done
    );

    modport master (
        output start, base_addr, sram_rdata, rd_i, rd_j,
        input  sram_addr, sram_ren, rd_data, busy, done
    );
endinterface

// File: rtl/sram16_to_mem8_unpack.sv
// Loads an 8x8 byte block (32 x 16-bit SRAM words) into a 64-byte buffer served by (i,j) index.
// Optional macro SRAM_BURST_EN: streaming reads, one word per cycle, capture pipelined one cycle behind.
module sram16_to_mem8_unpack #(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 16
) (
    input logic                   clock,
    input logic                   reset,
    sram16_to_mem8_unpack_if.slave bus
);

`ifdef SRAM_BURST_EN
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPT, S_DONE} state_e;
`endif

    state_e        state_q, state_d;
    logic [4:0]    k_q, k_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          ren;
    logic          wr_en;
    logic [4:0]    wr_k;
    logic [7:0]    buf_q [64];

`ifdef SRAM_BURST_EN
    logic          cap_vld_q, cap_vld_d;
    logic [4:0]    cap_k_q, cap_k_d;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        ren     = 1'b0;
        wr_en   = 1'b0;
        wr_k    = k_q;
`ifdef SRAM_BURST_EN
        // Read data lags the request by one cycle, so capture uses the index issued last cycle.
        cap_vld_d = (state_q == S_STREAM);
        cap_k_d   = k_q;
        wr_en     = cap_vld_q;
        wr_k      = cap_k_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    k_d     = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                ren = 1'b1;
                if (k_q == 5'd31) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d    = k_q + 5'd1;
                    addr_d = addr_q + AW'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`else
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    k_d     = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                ren     = 1'b1;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                wr_en = 1'b1;
                if (k_q == 5'd31) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 5'd1;
                    addr_d  = addr_q + AW'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            addr_q    <= '0;
`ifdef SRAM_BURST_EN
            cap_vld_q <= 1'b0;
            cap_k_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
`ifdef SRAM_BURST_EN
            cap_vld_q <= cap_vld_d;
            cap_k_q   <= cap_k_d;
`endif
        end
    end

    // Word k lands at bytes 2k (high byte) and 2k+1 (low byte); buffer is never cleared.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            buf_q[{wr_k, 1'b0}] <= bus.sram_rdata[DW-1 -: 8];
            buf_q[{wr_k, 1'b1}] <= bus.sram_rdata[DW-9 -: 8];
        end
    end

    assign bus.sram_addr = addr_q;
    assign bus.sram_ren  = ren;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rd_data   = buf_q[{bus.rd_i, bus.rd_j}];

endmodule

// File: tb/tb_sram16_to_mem8_unpack.sv
// Directed bench for sram16_to_mem8_unpack: timing, wrap, held start, mid-load reset, random loopback.
module tb_sram16_to_mem8_unpack;

`ifdef SRAM_BURST_EN
    localparam int DONE_CYC = 34;
    localparam bit BURST    = 1'b1;
`else
    localparam int DONE_CYC = 65;
    localparam bit BURST    = 1'b0;
`endif

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    logic [15:0] mem [0:262143];
    logic [7:0]  exp_buf [64];

    sram16_to_mem8_unpack_if #(.AW(18), .DW(16)) bus ();

    sram16_to_mem8_unpack #(.AW(18), .DW(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // SRAM model: read data appears one cycle after the enable.
    always @(posedge clock) begin
        if (bus.sram_ren) bus.sram_rdata <= mem[bus.sram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packer side: place a block in SRAM as words {even byte, odd byte}.
    task automatic fill_block(input logic [17:0] base, input bit counting);
        logic [17:0] a;
        for (int p = 0; p < 64; p++) exp_buf[p] = counting ? 8'(p) : 8'($urandom_range(0, 255));
        for (int m = 0; m < 32; m++) begin
            a = base + 18'(m);
            mem[a] = {exp_buf[2*m], exp_buf[2*m+1]};
        end
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                bus.rd_i = 3'(i);
                bus.rd_j = 3'(j);
                #1;
                chk(tag, bus.rd_data, exp_buf[i*8+j]);
            end
        end
        @(negedge clock);
    endtask

    // Called at a negedge with the DUT idle; the next posedge samples start (edge 0).
    task automatic do_load(input logic [17:0] base, input bit hold, input string tag);
        bit          exp_ren;
        int          k;
        logic [17:0] a;
        bus.base_addr = base;
        bus.start     = 1'b1;
        for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
            @(negedge clock);
            if (!hold) bus.start = 1'b0;
            if (BURST) begin
                exp_ren = (cyc >= 1) && (cyc <= 32);
                k       = cyc - 1;
            end else begin
                exp_ren = (cyc % 2 == 1) && (cyc <= 63);
                k       = (cyc - 1) / 2;
            end
            a = base + 18'(k);
            chk({tag, "_ren"}, bus.sram_ren, exp_ren);
            if (exp_ren) chk({tag, "_addr"}, bus.sram_addr, a);
            chk({tag, "_done"}, bus.done, cyc == DONE_CYC);
            chk({tag, "_busy"}, bus.busy, cyc <= DONE_CYC);
        end
        a = base + 18'd31;
        chk({tag, "_addr_hold"}, bus.sram_addr, a);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.rd_i      = '0;
        bus.rd_j      = '0;
        bus.sram_rdata = '0;

        // Reset, then five idle cycles.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_addr", bus.sram_addr, 18'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("idle_ren", bus.sram_ren, 1'b0);
            chk("idle_busy", bus.busy, 1'b0);
            chk("idle_done", bus.done, 1'b0);
        end

        // Counting pattern: word n = {2n, 2n+1}, expect rd_data(i,j) = 8i+j.
        fill_block(18'h00100, 1'b1);
        do_load(18'h00100, 1'b0, "cnt");
        check_buf("cnt_data");

        // Address wrap past all-ones.
        fill_block(18'h3FFF0, 1'b0);
        do_load(18'h3FFF0, 1'b0, "wrap");
        check_buf("wrap_data");

        // Start held high through a load and its done cycle: second load follows back to back.
        fill_block(18'h01000, 1'b0);
        fill_block(18'h02000, 1'b0);
        do_load(18'h01000, 1'b1, "hold1");
        do_load(18'h02000, 1'b0, "hold2");
        check_buf("hold_data");

        // Start and reset together: reset wins.
        bus.base_addr = 18'h00200;
        bus.start     = 1'b1;
        reset         = 1'b1;
        @(negedge clock);
        chk("rs_busy", bus.busy, 1'b0);
        chk("rs_ren", bus.sram_ren, 1'b0);
        bus.start = 1'b0;
        reset     = 1'b0;

        // Reset in cycle 20 of a load aborts it without a done pulse.
        fill_block(18'h00300, 1'b0);
        bus.base_addr = 18'h00300;
        bus.start     = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ren", bus.sram_ren, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("abort_idle_done", bus.done, 1'b0);
            chk("abort_idle_busy", bus.busy, 1'b0);
        end
        do_load(18'h00300, 1'b0, "reload");
        check_buf("reload_data");

        // Loopback of a random block at an arbitrary base.
        fill_block(18'h12345, 1'b0);
        do_load(18'h12345, 1'b0, "loop");
        check_buf("loop_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
